mem_stage: RTL and testbench

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage. Registers the execute result (destination register, write-enable, ALU data) together with the load/store request, runs the data-memory req/ack handshake, and aligns and extends load data. Delivers one registered writeback record per instruction. Holds the upstream pipeline with `stallreq_o` while a memory access is outstanding.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I memory-access stage: data-memory req/ack handshake, store lane formatting, load align/extend.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap record instead of silently aligning.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_memaddr_i,
  input  logic [31:0] ex_memdata_i,
  output logic        stallreq_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        misalign_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state, state_n;
  logic [4:0]  lat_wd, lat_wd_n;
  logic        lat_wreg, lat_wreg_n;
  logic [3:0]  lat_op, lat_op_n;
  logic [1:0]  lat_lo, lat_lo_n;
  logic [31:0] addr_q, addr_n;
  logic [3:0]  be_q, be_n;
  logic        we_q, we_n;
  logic [31:0] wdata_q, wdata_n;
  logic        wb_valid_q, wb_valid_n;
  logic [4:0]  wb_wd_q, wb_wd_n;
  logic        wb_wreg_q, wb_wreg_n;
  logic [31:0] wb_wdata_q, wb_wdata_n;
  logic        mis_q, mis_n;
  // One-entry holding slot for a record accepted on an edge that already retires another one.
  logic        pend_q, pend_n;
  logic [4:0]  pend_wd, pend_wd_n;
  logic        pend_wreg, pend_wreg_n;
  logic [31:0] pend_wdata, pend_wdata_n;
  logic        pend_mis, pend_mis_n;

  logic        is_load, is_store, is_half, is_word, trap;
  logic [1:0]  al_lo;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] rd_shift, ld_data;
  logic        take, slot;

  // Incoming request decode and bus formatting
  always_comb begin
    is_load  = (ex_memop_i >= OP_LB) && (ex_memop_i <= OP_LHU);
    is_store = (ex_memop_i >= OP_SB) && (ex_memop_i <= OP_SW);
    is_half  = (ex_memop_i == OP_LH) || (ex_memop_i == OP_LHU) || (ex_memop_i == OP_SH);
    is_word  = (ex_memop_i == OP_LW) || (ex_memop_i == OP_SW);
    if (is_word)      al_lo = 2'b00;
    else if (is_half) al_lo = {ex_memaddr_i[1], 1'b0};
    else              al_lo = ex_memaddr_i[1:0];
`ifdef MISALIGN_TRAP_EN
    trap = (is_half && ex_memaddr_i[0]) || (is_word && (ex_memaddr_i[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
    fmt_be    = 4'b0000;
    fmt_wdata = 32'd0;
    case (ex_memop_i)
      OP_SB: begin
        fmt_be    = 4'b0001 << al_lo;
        fmt_wdata = {4{ex_memdata_i[7:0]}};
      end
      OP_SH: begin
        fmt_be    = al_lo[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{ex_memdata_i[15:0]}};
      end
      OP_SW: begin
        fmt_be    = 4'b1111;
        fmt_wdata = ex_memdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = dmem_rdata_i >> {lat_lo, 3'b000};
    case (lat_op)
      OP_LB:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LH:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LBU:  ld_data = {24'd0, rd_shift[7:0]};
      OP_LHU:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  always_comb begin
    state_n      = state;
    lat_wd_n     = lat_wd;
    lat_wreg_n   = lat_wreg;
    lat_op_n     = lat_op;
    lat_lo_n     = lat_lo;
    addr_n       = addr_q;
    be_n         = be_q;
    we_n         = we_q;
    wdata_n      = wdata_q;
    wb_valid_n   = 1'b0;
    wb_wd_n      = wb_wd_q;
    wb_wreg_n    = wb_wreg_q;
    wb_wdata_n   = wb_wdata_q;
    mis_n        = 1'b0;
    pend_n       = pend_q;
    pend_wd_n    = pend_wd;
    pend_wreg_n  = pend_wreg;
    pend_wdata_n = pend_wdata;
    pend_mis_n   = pend_mis;
    take         = 1'b0;
    slot         = 1'b0;

    if (state == WAIT) begin
      if (dmem_ack_i) begin
        wb_valid_n = 1'b1;
        wb_wd_n    = lat_wd;
        wb_wreg_n  = we_q ? 1'b0 : lat_wreg;
        wb_wdata_n = we_q ? 32'd0 : ld_data;
        state_n    = IDLE;
        slot       = 1'b1;
        take       = ex_valid_i;
      end
    end else begin
      take = ex_valid_i;
      if (pend_q) begin
        wb_valid_n = 1'b1;
        wb_wd_n    = pend_wd;
        wb_wreg_n  = pend_wreg;
        wb_wdata_n = pend_wdata;
        mis_n      = pend_mis;
        pend_n     = 1'b0;
        slot       = 1'b1;
      end
    end

    if (take) begin
      if ((is_load || is_store) && !trap) begin
        lat_wd_n   = ex_wd_i;
        lat_wreg_n = ex_wreg_i;
        lat_op_n   = ex_memop_i;
        lat_lo_n   = al_lo;
        addr_n     = {ex_memaddr_i[31:2], 2'b00};
        be_n       = fmt_be;
        we_n       = is_store;
        wdata_n    = fmt_wdata;
        state_n    = WAIT;
      end else if (slot) begin
        pend_n       = 1'b1;
        pend_wd_n    = ex_wd_i;
        pend_wreg_n  = trap ? 1'b0 : ex_wreg_i;
        pend_wdata_n = trap ? 32'd0 : ex_wdata_i;
        pend_mis_n   = trap;
      end else begin
        wb_valid_n = 1'b1;
        wb_wd_n    = ex_wd_i;
        wb_wreg_n  = trap ? 1'b0 : ex_wreg_i;
        wb_wdata_n = trap ? 32'd0 : ex_wdata_i;
        mis_n      = trap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_wd     <= 5'd0;
      lat_wreg   <= 1'b0;
      lat_op     <= 4'd0;
      lat_lo     <= 2'd0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_wd_q    <= 5'd0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= 32'd0;
      mis_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_wd    <= 5'd0;
      pend_wreg  <= 1'b0;
      pend_wdata <= 32'd0;
      pend_mis   <= 1'b0;
    end else begin
      state      <= state_n;
      lat_wd     <= lat_wd_n;
      lat_wreg   <= lat_wreg_n;
      lat_op     <= lat_op_n;
      lat_lo     <= lat_lo_n;
      addr_q     <= addr_n;
      be_q       <= be_n;
      we_q       <= we_n;
      wdata_q    <= wdata_n;
      wb_valid_q <= wb_valid_n;
      wb_wd_q    <= wb_wd_n;
      wb_wreg_q  <= wb_wreg_n;
      wb_wdata_q <= wb_wdata_n;
      mis_q      <= mis_n;
      pend_q     <= pend_n;
      pend_wd    <= pend_wd_n;
      pend_wreg  <= pend_wreg_n;
      pend_wdata <= pend_wdata_n;
      pend_mis   <= pend_mis_n;
    end
  end

  assign dmem_req_o   = (state == WAIT);
  assign stallreq_o   = (state == WAIT) && !dmem_ack_i;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_wd_o      = wb_wd_q;
  assign wb_wreg_o    = wb_wreg_q;
  assign wb_wdata_o   = wb_wdata_q;
  assign misalign_o   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writeback records go to a queue, a monitor pops them on wb_valid_o.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic [3:0]  ex_memop_i;
  logic [31:0] ex_memaddr_i;
  logic [31:0] ex_memdata_i;
  logic        stallreq_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        misalign_o;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        mis;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
    .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i), .ex_memaddr_i(ex_memaddr_i),
    .ex_memdata_i(ex_memdata_i), .stallreq_o(stallreq_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_wdata_o(wb_wdata_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge.
  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] data);
    ex_valid_i   = 1'b1;
    ex_memop_i   = op;
    ex_wd_i      = wd;
    ex_wreg_i    = wreg;
    ex_wdata_i   = wdata;
    ex_memaddr_i = addr;
    ex_memdata_i = data;
    tick();
    ex_valid_i   = 1'b0;
  endtask

  // Called in the first WAIT cycle: check the bus, stall for `waits` cycles, then ack.
  task automatic serve(input string name, input int waits, input logic [31:0] rdata,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic e_we, input logic [31:0] e_wdata);
    chk({name, "_req"}, {31'd0, dmem_req_o}, 32'd1);
    chk({name, "_addr"}, dmem_addr_o, e_addr);
    chk({name, "_be"}, {28'd0, dmem_be_o}, {28'd0, e_be});
    chk({name, "_we"}, {31'd0, dmem_we_o}, {31'd0, e_we});
    if (e_we) chk({name, "_wdata"}, dmem_wdata_o, e_wdata);
    for (int i = 0; i < waits; i++) begin
      chk({name, "_stall"}, {31'd0, stallreq_o}, 32'd1);
      tick();
    end
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = rdata;
    #1;
    chk({name, "_stall_ack"}, {31'd0, stallreq_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0;
    chk({name, "_req_drop"}, {31'd0, dmem_req_o}, 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: wd=%0d wreg=%0b wdata=0x%08h", wb_wd_o, wb_wreg_o, wb_wdata_o);
        end else begin
          rec_t e;
          rec_t a;
          e = q.pop_front();
          a = '{wd: wb_wd_o, wreg: wb_wreg_o, wdata: wb_wdata_o, mis: misalign_o};
          if (a !== e) begin
            errors++;
            $display("FAIL wb_record: got wd=%0d wreg=%0b wdata=0x%08h mis=%0b expected wd=%0d wreg=%0b wdata=0x%08h mis=%0b",
                     a.wd, a.wreg, a.wdata, a.mis, e.wd, e.wreg, e.wdata, e.mis);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; ex_wd_i = '0; ex_wreg_i = 1'b0; ex_wdata_i = '0;
    ex_memop_i = '0; ex_memaddr_i = '0; ex_memdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wb", {26'd0, wb_valid_o, wb_wd_o}, 32'd0);
    chk("rst_wbdata", wb_wdata_o, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);

    // NOP pass-through
    q.push_back('{wd: 5'd5, wreg: 1'b1, wdata: 32'h1234, mis: 1'b0});
    issue(4'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    chk("nop_stall", {31'd0, stallreq_o}, 32'd0);
    chk("nop_valid", {31'd0, wb_valid_o}, 32'd1);
    tick();
    chk("nop_pulse", {31'd0, wb_valid_o}, 32'd0);

    // memop 9 behaves as NOP
    q.push_back('{wd: 5'd2, wreg: 1'b1, wdata: 32'h77, mis: 1'b0});
    issue(4'd9, 5'd2, 1'b1, 32'h77, 32'h0, 32'h0);
    chk("op9_req", {31'd0, dmem_req_o}, 32'd0);
    tick();

    // Ack while idle is ignored
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("idle_ack_req", {31'd0, dmem_req_o}, 32'd0);
    tick();

    // Loads
    q.push_back('{wd: 5'd7, wreg: 1'b1, wdata: 32'hFFFFFF80, mis: 1'b0});
    issue(4'd1, 5'd7, 1'b1, 32'h0, 32'h103, 32'h0);
    serve("lb", 3, 32'h80123456, 32'h100, 4'b0000, 1'b0, 32'h0);
    q.push_back('{wd: 5'd8, wreg: 1'b1, wdata: 32'h00008765, mis: 1'b0});
    issue(4'd5, 5'd8, 1'b1, 32'h0, 32'h102, 32'h0);
    serve("lhu", 0, 32'h87654321, 32'h100, 4'b0000, 1'b0, 32'h0);
    q.push_back('{wd: 5'd9, wreg: 1'b1, wdata: 32'hFFFF9ABC, mis: 1'b0});
    issue(4'd2, 5'd9, 1'b1, 32'h0, 32'h100, 32'h0);
    serve("lh", 1, 32'h00009ABC, 32'h100, 4'b0000, 1'b0, 32'h0);
    q.push_back('{wd: 5'd10, wreg: 1'b1, wdata: 32'h000000F2, mis: 1'b0});
    issue(4'd4, 5'd10, 1'b1, 32'h0, 32'h101, 32'h0);
    serve("lbu", 0, 32'h0000F200, 32'h100, 4'b0000, 1'b0, 32'h0);

    // Stores
    q.push_back('{wd: 5'd3, wreg: 1'b0, wdata: 32'h0, mis: 1'b0});
    issue(4'd7, 5'd3, 1'b1, 32'h0, 32'h202, 32'h0000ABCD);
    serve("sh", 1, 32'h0, 32'h200, 4'b1100, 1'b1, 32'hABCDABCD);
    q.push_back('{wd: 5'd4, wreg: 1'b0, wdata: 32'h0, mis: 1'b0});
    issue(4'd6, 5'd4, 1'b1, 32'h0, 32'h201, 32'h0000005A);
    serve("sb", 0, 32'h0, 32'h200, 4'b0010, 1'b1, 32'h5A5A5A5A);
    q.push_back('{wd: 5'd6, wreg: 1'b0, wdata: 32'h0, mis: 1'b0});
    issue(4'd8, 5'd6, 1'b1, 32'h0, 32'h400, 32'hDEADBEEF);
    serve("sw", 2, 32'h0, 32'h400, 4'b1111, 1'b1, 32'hDEADBEEF);
    tick();

    // Back-to-back: ADD presented in the LW ack cycle
    q.push_back('{wd: 5'd8, wreg: 1'b1, wdata: 32'h11223344, mis: 1'b0});
    q.push_back('{wd: 5'd9, wreg: 1'b1, wdata: 32'h55, mis: 1'b0});
    issue(4'd3, 5'd8, 1'b1, 32'h0, 32'h500, 32'h0);
    chk("b2b_req", {31'd0, dmem_req_o}, 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h11223344;
    ex_valid_i = 1'b1; ex_memop_i = 4'd0; ex_wd_i = 5'd9; ex_wreg_i = 1'b1; ex_wdata_i = 32'h55;
    #1;
    chk("b2b_stall", {31'd0, stallreq_o}, 32'd0);
    tick();
    dmem_ack_i = 1'b0; ex_valid_i = 1'b0;
    chk("b2b_first", {26'd0, wb_valid_o, wb_wd_o}, {26'd0, 1'b1, 5'd8});
    tick();
    chk("b2b_second", {26'd0, wb_valid_o, wb_wd_o}, {26'd0, 1'b1, 5'd9});
    tick();
    chk("b2b_done", {31'd0, wb_valid_o}, 32'd0);

    // Reset in the second WAIT cycle, then a late ack
    issue(4'd3, 5'd11, 1'b1, 32'h0, 32'h600, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_req", {31'd0, dmem_req_o}, 32'd0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    tick();
    dmem_ack_i = 1'b0;
    chk("rstw_wb", {31'd0, wb_valid_o}, 32'd0);
    chk("rstw_addr", dmem_addr_o, 32'd0);
    chk("rstw_wbdata", {wb_wdata_o[31:6], wb_wd_o, wb_wreg_o}, 32'd0);
    chk("rstw_stall", {31'd0, stallreq_o}, 32'd0);
    tick();

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    q.push_back('{wd: 5'd4, wreg: 1'b0, wdata: 32'h0, mis: 1'b1});
    issue(4'd3, 5'd4, 1'b1, 32'h0, 32'h301, 32'h0);
    chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    tick();
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);
`else
    q.push_back('{wd: 5'd4, wreg: 1'b1, wdata: 32'hCAFEF00D, mis: 1'b0});
    issue(4'd3, 5'd4, 1'b1, 32'h0, 32'h301, 32'h0);
    serve("mis_lw", 0, 32'hCAFEF00D, 32'h300, 4'b0000, 1'b0, 32'h0);
`endif

    tick(); tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
